// File: rtl/wave_capture_pkg.sv
// Shared definitions for the wave capture controller: state encodings,
// capture geometry and the codec-to-display sample conversion.
package wave_capture_pkg;

  typedef enum logic [1:0] {
    WC_ARMED  = 2'd0,
    WC_ACTIVE = 2'd1,
    WC_WAIT   = 2'd2,
    WC_BAD    = 2'd3
  } wc_state_e;

  localparam int unsigned SAMPLE_INDEX_WIDTH  = 8;
  localparam int unsigned SAMPLES_PER_CAPTURE = 256;

  // Signed top byte to offset-binary for the display.
  function automatic logic [7:0] to_display(input logic [7:0] top_byte);
    return top_byte ^ 8'h80;
  endfunction

endpackage

// File: rtl/wave_trigger.sv
// Trigger detector: positive-going zero crossing, or a forced trigger after
// TIMEOUT strobes accepted while armed.
module wave_trigger #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    strobe,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic                    armed,
  input  logic                    clear,
  output logic                    trigger
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  logic [SAMPLE_WIDTH-1:0] prev_sample_r;
  logic [15:0]             timeout_count_r;
  logic                    crossing_s;
  logic                    timeout_s;

  assign crossing_s = prev_sample_r[SAMPLE_WIDTH-1] & ~sample[SAMPLE_WIDTH-1];
  assign timeout_s  = (timeout_count_r == TIMEOUT_LAST);
  assign trigger    = strobe & armed & (crossing_s | timeout_s);

  // Previous-sample history and armed-strobe counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_sample_r   <= '0;
      timeout_count_r <= 16'd0;
    end else begin
      if (strobe) begin
        prev_sample_r <= sample;
      end
      if (clear) begin
        timeout_count_r <= 16'd0;
      end else if (strobe && armed) begin
        timeout_count_r <= timeout_count_r + 16'd1;
      end
    end
  end

endmodule

// File: rtl/wave_capture.sv
// Double-buffered capture controller: writes 256 samples after a trigger into
// the hidden buffer, then flips the displayed buffer during blanking.
module wave_capture
  import wave_capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_sample_ready,
  input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
  input  logic                    wave_display_idle,
  output logic [8:0]              write_address,
  output logic [7:0]              write_sample,
  output logic                    write_enable,
  output logic                    read_index,
  output logic [1:0]              capture_state
);

  localparam logic [7:0] LAST_INDEX = 8'(SAMPLES_PER_CAPTURE - 1);

  wc_state_e  state_r, state_s;
  logic [7:0] sample_count_r, sample_count_s;
  logic       read_index_r, read_index_s;
  logic [8:0] write_address_r, write_address_s;
  logic [7:0] write_sample_r, write_sample_s;
  logic       write_enable_r, write_enable_s;
  logic       trigger_s;
  logic       armed_s;
  logic       clear_s;
  logic [7:0] display_sample_s;

  assign armed_s          = (state_r == WC_ARMED);
  assign display_sample_s = to_display(new_sample_in[SAMPLE_WIDTH-1 -: 8]);

  wave_trigger #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .TIMEOUT     (TIMEOUT)
  ) u_trigger (
    .clk    (clk),
    .reset  (reset),
    .strobe (new_sample_ready),
    .sample (new_sample_in),
    .armed  (armed_s),
    .clear  (clear_s),
    .trigger(trigger_s)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_s         = state_r;
    sample_count_s  = sample_count_r;
    read_index_s    = read_index_r;
    write_address_s = write_address_r;
    write_sample_s  = write_sample_r;
    write_enable_s  = 1'b0;
    clear_s         = 1'b0;
    case (state_r)
      WC_ARMED: begin
        if (trigger_s) begin
          write_enable_s  = 1'b1;
          write_address_s = {~read_index_r, 8'd0};
          write_sample_s  = display_sample_s;
          sample_count_s  = 8'd1;
          state_s         = WC_ACTIVE;
        end else begin
          state_s = WC_ARMED;
        end
      end
      WC_ACTIVE: begin
        if (new_sample_ready) begin
          write_enable_s  = 1'b1;
          write_address_s = {~read_index_r, sample_count_r};
          write_sample_s  = display_sample_s;
          sample_count_s  = sample_count_r + 8'd1;
          state_s         = (sample_count_r == LAST_INDEX) ? WC_WAIT : WC_ACTIVE;
        end else begin
          state_s = WC_ACTIVE;
        end
      end
      WC_WAIT: begin
        if (wave_display_idle) begin
          // Keep the address MSB pointing at the new hidden buffer.
          read_index_s    = ~read_index_r;
          write_address_s = {read_index_r, write_address_r[7:0]};
          clear_s         = 1'b1;
          state_s         = WC_ARMED;
        end else begin
          state_s = WC_WAIT;
        end
      end
      default: begin
        state_s = WC_ARMED;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= WC_ARMED;
      sample_count_r  <= 8'd0;
      read_index_r    <= 1'b0;
      write_address_r <= 9'h100;
      write_sample_r  <= 8'd0;
      write_enable_r  <= 1'b0;
    end else begin
      state_r         <= state_s;
      sample_count_r  <= sample_count_s;
      read_index_r    <= read_index_s;
      write_address_r <= write_address_s;
      write_sample_r  <= write_sample_s;
      write_enable_r  <= write_enable_s;
    end
  end

  assign write_address = write_address_r;
  assign write_sample  = write_sample_r;
  assign write_enable  = write_enable_r;
  assign read_index    = read_index_r;
  assign capture_state = state_r;

endmodule

// File: tb/tb_wave_capture.sv
// Directed self-checking bench for wave_capture (TIMEOUT reduced to 4).
module tb_wave_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        new_sample_ready = 1'b0;
  logic [15:0] new_sample_in = 16'd0;
  logic        wave_display_idle = 1'b0;
  logic [8:0]  write_address;
  logic [7:0]  write_sample;
  logic        write_enable;
  logic        read_index;
  logic [1:0]  capture_state;

  int checks = 0;
  int errors = 0;

  wave_capture #(.SAMPLE_WIDTH(16), .TIMEOUT(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .new_sample_ready (new_sample_ready),
    .new_sample_in    (new_sample_in),
    .wave_display_idle(wave_display_idle),
    .write_address    (write_address),
    .write_sample     (write_sample),
    .write_enable     (write_enable),
    .read_index       (read_index),
    .capture_state    (capture_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One strobe; returns at the negedge where its write (if any) is visible.
  task automatic strobe(input logic [15:0] val);
    @(negedge clk);
    new_sample_ready = 1'b1;
    new_sample_in    = val;
    @(negedge clk);
    new_sample_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(capture_state), 32'd0);
    check({tag, "_ridx"},  32'(read_index),    32'd0);
    check({tag, "_addr"},  32'(write_address), 32'h100);
    check({tag, "_samp"},  32'(write_sample),  32'h00);
    check({tag, "_we"},    32'(write_enable),  32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b1;
    @(negedge clk);

    // Zero crossing -5 -> +3 triggers on the second strobe.
    strobe(16'hFFFB);
    check("neg_no_we", 32'(write_enable), 32'd0);
    check("neg_state", 32'(capture_state), 32'd0);
    strobe(16'h0003);
    check("trig_we",    32'(write_enable),  32'd1);
    check("trig_addr",  32'(write_address), 32'h100);
    check("trig_samp",  32'(write_sample),  32'h80);
    check("trig_state", 32'(capture_state), 32'd1);
    @(negedge clk);
    check("we_pulse",  32'(write_enable),  32'd0);
    check("addr_hold", 32'(write_address), 32'h100);

    // Back-to-back ramp fills indices 1..255.
    new_sample_ready = 1'b1;
    for (int n = 0; n < 255; n++) begin
      new_sample_in = 16'(n << 8);
      @(negedge clk);
      check("ramp_we",   32'(write_enable),  32'd1);
      check("ramp_addr", 32'(write_address), 32'h101 + 32'(n));
      check("ramp_samp", 32'(write_sample),  (32'h80 + 32'(n)) & 32'hFF);
    end
    new_sample_ready = 1'b0;
    check("full_state", 32'(capture_state), 32'd2);

    strobe(16'd500);
    check("wait_drop_we", 32'(write_enable),  32'd0);
    check("wait_state",   32'(capture_state), 32'd2);

    repeat (100) @(negedge clk);
    check("idle_lo_state", 32'(capture_state), 32'd2);
    check("idle_lo_ridx",  32'(read_index),    32'd0);
    wave_display_idle = 1'b1;
    @(negedge clk);
    wave_display_idle = 1'b0;
    check("flip_ridx",  32'(read_index),    32'd1);
    check("flip_state", 32'(capture_state), 32'd0);
    check("flip_addr",  32'(write_address), 32'h0FF);

    // Constant +100: no crossing, forced trigger on the 4th strobe.
    for (int k = 0; k < 3; k++) begin
      strobe(16'd100);
      check("to_no_we", 32'(write_enable), 32'd0);
    end
    strobe(16'd100);
    check("to_we",    32'(write_enable),  32'd1);
    check("to_addr",  32'(write_address), 32'h000);
    check("to_samp",  32'(write_sample),  32'h80);
    check("to_state", 32'(capture_state), 32'd1);

    new_sample_ready = 1'b1;
    for (int n = 0; n < 255; n++) begin
      new_sample_in = 16'(n << 8);
      @(negedge clk);
      check("b0_addr", 32'(write_address), 32'h001 + 32'(n));
      check("b0_we",   32'(write_enable),  32'd1);
    end
    new_sample_ready = 1'b0;
    check("b0_full_state", 32'(capture_state), 32'd2);

    // Strobe (+7) and idle together: flip, drop, prev_sample still updated.
    @(negedge clk);
    new_sample_ready  = 1'b1;
    new_sample_in     = 16'd7;
    wave_display_idle = 1'b1;
    @(negedge clk);
    new_sample_ready  = 1'b0;
    wave_display_idle = 1'b0;
    check("both_ridx",  32'(read_index),    32'd0);
    check("both_we",    32'(write_enable),  32'd0);
    check("both_state", 32'(capture_state), 32'd0);

    strobe(16'd2);
    check("prev_upd_no_we", 32'(write_enable), 32'd0);
    strobe(16'hFFFD);
    strobe(16'd2);
    check("re_trig_we",    32'(write_enable),  32'd1);
    check("re_trig_addr",  32'(write_address), 32'h100);
    check("re_trig_state", 32'(capture_state), 32'd1);

    // Fill to index 40, then reset mid-capture.
    new_sample_ready = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      new_sample_in = 16'(n << 8);
      @(negedge clk);
    end
    new_sample_ready = 1'b0;
    check("idx40_addr", 32'(write_address), 32'h128);
    check("idx40_samp", 32'(write_sample),  32'hA8);
    #2 reset = 1'b0;
    #1 check_reset_values("midrst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_state", 32'(capture_state), 32'd0);

    strobe(16'd5);
    check("post_rst_no_we", 32'(write_enable), 32'd0);
    strobe(16'hFFFF);
    check("post_rst_neg_no_we", 32'(write_enable), 32'd0);
    strobe(16'd1);
    check("post_rst_trig_we",   32'(write_enable),  32'd1);
    check("post_rst_trig_addr", 32'(write_address), 32'h100);
    check("post_rst_trig_samp", 32'(write_sample),  32'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
